csr_store_buffer: RTL and testbench
===================================

# csr_store_buffer

Downstream stage of the post-processing unit (ReLU → 2×2 max-pool → CSR encoder). It captures the encoder's per-nonzero `store` pulses (`row`, `data`) and the final `index_pointer` vector on `done`. It then drains one compressed 6×6 feature map as a stream of packed 32-bit words over a valid/ready port toward the output buffer or host bus. The next map cannot be collected until the drain completes.

## Interface
Parameters:
- DEPTH, 36: max nonzero entries per map (6×6 pooled output)
- PTR_W, 56: index_pointer width (7 pointers × 8 bits)

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-high
- clear  in  1  synchronous abort; discards the current map and returns to COLLECT
- store  in  1  encoder strobe: one nonzero element present on row/data
- row  in  4  column index of the nonzero element from the encoder
- data  in  8  nonzero pooled value
- done  in  1  encoder strobe: map complete, index_pointer valid
- index_pointer  in  56  CSR row pointers; ptr0 in [55:48] … ptr6 in [7:0]
- rd_valid  out  1  rd_data holds a valid word
- rd_ready  in  1  consumer accepts the word when rd_valid & rd_ready
- rd_data  out  32  packed output word
- rd_last  out  1  marks the final word of the map; qualified by rd_valid
- nnz_count  out  6  entries stored for the current map
- busy  out  1  high in DRAIN
- overflow  out  1  sticky: an entry was dropped

## Operation
- States: COLLECT (reset state) and DRAIN.
- COLLECT, store=1:
  - If nnz_count < DEPTH: write {row,data} to entry[nnz_count], then nnz_count+1.
  - Otherwise: drop the entry and set overflow.
- COLLECT, done=1: latch index_pointer, reset the read word pointer to 0, go to DRAIN.
  - If store and done are both high in the same cycle, the entry is written first, so it is included in the map.
- DRAIN, word order (W = 2 + ceil(nnz_count/2) words total):
  - word0 = index_pointer[55:24]
  - word1 = {index_pointer[23:0], 2'b00, nnz_count}
  - word k≥2 = {4'h0, row_a, data_a, 4'h0, row_b, data_b}, where a = entry 2(k−2) and b = entry 2(k−2)+1
  - If nnz_count is odd, the lower half of the last word is 16'h0000.
- rd_valid = (state==DRAIN). rd_last is high on word W−1.
- Each handshake advances the word pointer by one.
- Handshake on the rd_last word: go to COLLECT and set nnz_count=0. overflow is not cleared.
- DRAIN, store=1: the entry is dropped and overflow is set. done is ignored in DRAIN.
- clear has priority over every other input:
  - Next state COLLECT, with nnz_count=0, overflow=0, rd_valid=0.
  - Storage contents are don't-care.
- Storage is a 36×12 register array, written only in COLLECT.

## Timing
- Reset values: rd_valid=0, rd_last=0, rd_data=0, busy=0, nnz_count=0, overflow=0; state COLLECT.
- nnz_count updates the cycle after store.
- done sampled at edge T: rd_valid=1 and busy=1 from T+1; word0 is presented at T+1.
- rd_data and rd_last are combinational from the latched pointer, the storage and the word pointer.
  - They are stable while rd_valid & !rd_ready.
  - They change only after a handshake edge.
- With rd_ready held high, one word moves per cycle. The map takes W cycles, and COLLECT is re-entered at T+1+W.
- Handshake on rd_last at edge E: rd_valid=0 after E, and store is accepted from the cycle after E onward.
- rst asserted mid-DRAIN: outputs go to reset values immediately (asynchronous) and the partial map is lost.

## Test plan
- 3 stores (row/data = 1/0x11, 4/0x22, 5/0x33), then done with index_pointer = 0x00_01_01_02_02_03_03:
  - rd_data = 0x00010102, then 0x02030303, then 0x01110422, then 0x05330000 (rd_last=1)
  - nnz_count=3 before the drain, 0 after it.
- done with no stores: exactly 2 words; word1 low byte = 0x00; rd_last on word1.
- 37 consecutive stores then done: nnz_count=36, overflow=1; 20 words drained; the 37th entry is absent.
- Drain of 4 entries with rd_ready toggling 1,0,0,1,…: each word is held unchanged while rd_ready=0; no word is skipped or duplicated.
- store and done in the same cycle as the 2nd entry: that entry is present in word2 lower half; a store during DRAIN sets overflow and is not emitted.
- clear asserted during DRAIN on word1, and rst asserted mid-COLLECT:
  - rd_valid=0 and nnz_count=0 the next cycle (clear) or immediately (rst).
  - A following 1-store map drains correctly.

Source files
------------

// File: rtl/csr_store_buffer_if.sv
// Word stream from the CSR store buffer to the output buffer or host bus.
// A word moves on every cycle in which valid and ready are both high.
interface csr_store_buffer_if;
  logic        valid;
  logic        ready;
  logic [31:0] data;
  logic        last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/csr_store_buffer.sv
// Captures one CSR-encoded pooled map, then drains it as packed 32-bit words; word0 appears the cycle after done.
// The output word is held while valid & !ready, and no new map is collected until the last word is accepted.
module csr_store_buffer #(
  parameter int DEPTH = 36,
  parameter int PTR_W = 56
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               store,
  input  logic [3:0]         row,
  input  logic [7:0]         data,
  input  logic               done,
  input  logic [PTR_W-1:0]   index_pointer,
  csr_store_buffer_if.master rd,
  output logic [5:0]         nnz_count,
  output logic               busy,
  output logic               overflow
);

  typedef struct packed {
    logic [3:0] row;
    logic [7:0] data;
  } entry_t;

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] DRAIN   = 1'b1;
  localparam logic [5:0] DEPTH_C = 6'(DEPTH);

  logic [0:0]       state;
  logic [5:0]       wptr;
  logic [PTR_W-1:0] ptr_q;
  entry_t           mem [DEPTH];

  logic             room;
  logic             wr_en;
  logic             fire;
  logic [5:0]       last_idx;
  logic [5:0]       idx_a;
  logic [5:0]       idx_b;
  entry_t           ent_a;
  entry_t           ent_b;

  assign room     = (nnz_count < DEPTH_C);
  assign wr_en    = !clear && (state == COLLECT) && store && room;
  assign fire     = rd.valid && rd.ready;
  assign last_idx = 6'd1 + ((nnz_count + 6'd1) >> 1);

  // Entry words start at word pointer 2 and carry two entries each.
  assign idx_a = (wptr - 6'd2) << 1;
  assign idx_b = idx_a | 6'd1;
  assign ent_a = (idx_a < DEPTH_C)   ? mem[idx_a] : '0;
  assign ent_b = (idx_b < nnz_count) ? mem[idx_b] : '0;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[nnz_count] <= '{row: row, data: data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= COLLECT;
      nnz_count <= 6'd0;
      overflow  <= 1'b0;
      wptr      <= 6'd0;
      ptr_q     <= '0;
    end else if (clear) begin
      state     <= COLLECT;
      nnz_count <= 6'd0;
      overflow  <= 1'b0;
      wptr      <= 6'd0;
    end else begin
      case (state)
        COLLECT: begin
          if (store) begin
            if (room) begin
              nnz_count <= nnz_count + 6'd1;
            end else begin
              overflow <= 1'b1;
            end
          end
          if (done) begin
            ptr_q <= index_pointer;
            wptr  <= 6'd0;
            state <= DRAIN;
          end
        end
        default: begin
          if (store) begin
            overflow <= 1'b1;
          end
          if (fire) begin
            if (wptr == last_idx) begin
              state     <= COLLECT;
              nnz_count <= 6'd0;
              wptr      <= 6'd0;
            end else begin
              wptr <= wptr + 6'd1;
            end
          end
        end
      endcase
    end
  end

  assign rd.valid = (state == DRAIN);
  assign busy     = (state == DRAIN);

  always_comb begin
    rd.data = '0;
    rd.last = 1'b0;
    if (state == DRAIN) begin
      rd.last = (wptr == last_idx);
      if (wptr == 6'd0) begin
        rd.data = ptr_q[PTR_W-1 -: 32];
      end else if (wptr == 6'd1) begin
        rd.data = {ptr_q[PTR_W-33:0], 2'b00, nnz_count};
      end else begin
        rd.data = {4'h0, ent_a, 4'h0, ent_b};
      end
    end
  end

endmodule

// File: tb/tb_csr_store_buffer.sv
// Directed bench for csr_store_buffer: stimulus queues expected {last,word} pairs,
// a negedge monitor compares every presented word against the queue head.
module tb_csr_store_buffer;
  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        store;
  logic [3:0]  row;
  logic [7:0]  data;
  logic        done;
  logic [55:0] index_pointer;
  logic [5:0]  nnz_count;
  logic        busy;
  logic        overflow;

  csr_store_buffer_if rd_if ();

  csr_store_buffer #(.DEPTH(36), .PTR_W(56)) dut (
    .clk           (clk),
    .rst           (rst),
    .clear         (clear),
    .store         (store),
    .row           (row),
    .data          (data),
    .done          (done),
    .index_pointer (index_pointer),
    .rd            (rd_if),
    .nnz_count     (nnz_count),
    .busy          (busy),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          rdy_mode = 0;
  int          rdy_ph = 0;
  logic [32:0] exp_q[$];
  logic [11:0] model_ent[$];

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rd_if.valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word: got %h want none", rd_if.data);
      end else begin
        chk("word", {rd_if.last, rd_if.data}, exp_q[0]);
        if (rd_if.ready) void'(exp_q.pop_front());
      end
    end
  end

  // mode 0: ready high, mode 1: ready pattern 1,0,0 repeating, mode 2: driven by the test
  task automatic tick();
    @(posedge clk);
    #1;
    if (rdy_mode == 0) begin
      rd_if.ready = 1'b1;
    end else if (rdy_mode == 1) begin
      rdy_ph = (rdy_ph + 1) % 3;
      rd_if.ready = (rdy_ph == 0);
    end
  endtask

  task automatic store_entry(input logic [3:0] r, input logic [7:0] d);
    store = 1'b1;
    row = r;
    data = d;
    tick();
    store = 1'b0;
    if (model_ent.size() < 36) model_ent.push_back({r, d});
  endtask

  task automatic issue_done(input logic [55:0] p);
    index_pointer = p;
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("valid_after_done", 33'(rd_if.valid), 33'd1);
    chk("busy_after_done", 33'(busy), 33'd1);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rd_if.valid) && n < 300) begin
      tick();
      n++;
    end
    total++;
    if (n >= 300) begin
      bad++;
      $display("FAIL %s_timeout: got %0d words left want 0", name, exp_q.size());
    end
  endtask

  task automatic push_map(input logic [55:0] p);
    int n;
    int nw;
    logic [11:0] b;
    n = model_ent.size();
    nw = (n + 1) / 2;
    exp_q.push_back({nw == 0, p[55:24]});
    exp_q.push_back({nw == 0, p[23:0], 2'b00, 6'(n)});
    for (int k = 0; k < nw; k++) begin
      b = (2 * k + 1 < n) ? model_ent[2 * k + 1] : 12'h000;
      exp_q.push_back({k == nw - 1, 4'h0, model_ent[2 * k], 4'h0, b});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    clear = 1'b0;
    store = 1'b0;
    done = 1'b0;
    row = 4'h0;
    data = 8'h00;
    index_pointer = '0;
    rd_if.ready = 1'b1;
    #2;
    chk("rst_valid", 33'(rd_if.valid), 33'd0);
    chk("rst_last", 33'(rd_if.last), 33'd0);
    chk("rst_data", 33'(rd_if.data), 33'd0);
    chk("rst_busy", 33'(busy), 33'd0);
    chk("rst_nnz", 33'(nnz_count), 33'd0);
    chk("rst_ovf", 33'(overflow), 33'd0);
    tick();
    tick();
    rst = 1'b0;

    // three entries, odd count pads last word
    store_entry(4'd1, 8'h11);
    store_entry(4'd4, 8'h22);
    store_entry(4'd5, 8'h33);
    chk("t1_nnz", 33'(nnz_count), 33'd3);
    exp_q.push_back({1'b0, 32'h00010102});
    exp_q.push_back({1'b0, 32'h02030303});
    exp_q.push_back({1'b0, 32'h01110422});
    exp_q.push_back({1'b1, 32'h05330000});
    issue_done(56'h00010102020303);
    wait_drain("t1");
    chk("t1_nnz_after", 33'(nnz_count), 33'd0);
    chk("t1_valid_after", 33'(rd_if.valid), 33'd0);
    chk("t1_busy_after", 33'(busy), 33'd0);

    // empty map: two header words only
    exp_q.push_back({1'b0, 32'hAABBCCDD});
    exp_q.push_back({1'b1, 32'hEEFF1100});
    issue_done(56'hAABBCCDDEEFF11);
    wait_drain("t2");
    chk("t2_valid_after", 33'(rd_if.valid), 33'd0);

    // overflow: 37 stores, the last is dropped
    model_ent.delete();
    for (int i = 0; i < 37; i++) store_entry(4'(i), 8'(i + 1));
    chk("t3_nnz", 33'(nnz_count), 33'd36);
    chk("t3_ovf", 33'(overflow), 33'd1);
    push_map(56'h0102030405A5B6);
    issue_done(56'h0102030405A5B6);
    wait_drain("t3");
    chk("t3_nnz_after", 33'(nnz_count), 33'd0);
    chk("t3_ovf_sticky", 33'(overflow), 33'd1);

    // clear in COLLECT drops overflow; then drain under ready 1,0,0 pattern
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t4_ovf_cleared", 33'(overflow), 33'd0);
    chk("t4_nnz_cleared", 33'(nnz_count), 33'd0);
    rdy_mode = 1;
    rdy_ph = 0;
    rd_if.ready = 1'b1;
    store_entry(4'h3, 8'h0A);
    store_entry(4'h7, 8'h0B);
    store_entry(4'hC, 8'hC0);
    store_entry(4'hF, 8'hFF);
    exp_q.push_back({1'b0, 32'h11223344});
    exp_q.push_back({1'b0, 32'h55667704});
    exp_q.push_back({1'b0, 32'h030A070B});
    exp_q.push_back({1'b1, 32'h0CC00FFF});
    issue_done(56'h11223344556677);
    wait_drain("t4");
    rdy_mode = 0;
    rd_if.ready = 1'b1;

    // store together with done is kept; store during DRAIN is dropped
    store_entry(4'h2, 8'h21);
    exp_q.push_back({1'b0, 32'h01020304});
    exp_q.push_back({1'b0, 32'h05060702});
    exp_q.push_back({1'b1, 32'h02210662});
    store = 1'b1;
    row = 4'h6;
    data = 8'h62;
    issue_done(56'h01020304050607);
    row = 4'h9;
    data = 8'h99;
    tick();
    store = 1'b0;
    wait_drain("t5");
    chk("t5_ovf", 33'(overflow), 33'd1);
    chk("t5_nnz_after", 33'(nnz_count), 33'd0);

    // clear while word1 is stalled, then a one-entry map
    rdy_mode = 2;
    rd_if.ready = 1'b1;
    store_entry(4'h1, 8'h01);
    store_entry(4'h2, 8'h02);
    exp_q.push_back({1'b0, 32'hA0A1A2A3});
    exp_q.push_back({1'b0, 32'hA4A5A602});
    issue_done(56'hA0A1A2A3A4A5A6);
    tick();
    rd_if.ready = 1'b0;
    tick();
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t6_valid_clear", 33'(rd_if.valid), 33'd0);
    chk("t6_nnz_clear", 33'(nnz_count), 33'd0);
    chk("t6_ovf_clear", 33'(overflow), 33'd0);
    exp_q.delete();
    rdy_mode = 0;
    rd_if.ready = 1'b1;
    store_entry(4'h2, 8'h5A);
    exp_q.push_back({1'b0, 32'h0B0C0D0E});
    exp_q.push_back({1'b0, 32'h0F101101});
    exp_q.push_back({1'b1, 32'h025A0000});
    issue_done(56'h0B0C0D0E0F1011);
    wait_drain("t6");

    // asynchronous reset mid-COLLECT, then a one-entry map
    store_entry(4'h4, 8'h44);
    store_entry(4'h5, 8'h55);
    rst = 1'b1;
    #1;
    chk("t7_nnz_rst", 33'(nnz_count), 33'd0);
    chk("t7_valid_rst", 33'(rd_if.valid), 33'd0);
    tick();
    rst = 1'b0;
    exp_q.delete();
    store_entry(4'hE, 8'hE7);
    exp_q.push_back({1'b0, 32'h00000000});
    exp_q.push_back({1'b0, 32'h00000001});
    exp_q.push_back({1'b1, 32'h0EE70000});
    issue_done(56'h00000000000000);
    wait_drain("t7");
    chk("t7_nnz_after", 33'(nnz_count), 33'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
